pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Sequencer for the 8-bit, 2-operand pipeline (instr = {func[1:0], rdst[2:0], rsrc[2:0]}).
// - Sits beside the IF/ID register and tracks the in-flight EX and WB instructions.
// - Generates the hold, bubble and forwarding controls for the IF/ID register and the EX stage.
// - Sequences the multi-cycle op (func 2'b11) through EX.
// PARAMETERS
// - MC_CYCLES  4   EX occupancy of func 2'b11, in cycles. Legal range 1..15; 1 = single-cycle.
// - SCNT_W     16  width of the saturating stall-cycle counter.
// PORTS
// - clk           in   1       clock, rising edge
// - reset         in   1       synchronous, active-high
// - id_valid      in   1       IF/ID holds a valid instruction (IF/ID status bit)
// - id_func       in   2       ID opcode
// - id_rdst       in   3       ID destination, also first source (rdst = rdst op rsrc)
// - id_rsrc       in   3       ID second source
// - pc_hold       out  1       freeze PC this cycle
// - ifid_hold     out  1       IF/ID keeps its contents this cycle (equals pc_hold)
// - ex_valid      out  1       EX holds a valid instruction
// - ex_func       out  2       EX opcode
// - ex_rdst       out  3       EX destination
// - wb_valid      out  1       WB holds a valid instruction; register-file write enable
// - wb_rdst       out  3       WB destination
// - mc_busy       out  1       FSM is in MC_BUSY
// - fwd_rdst_sel  out  2       rdst operand source: 00 regfile, 01 EX result, 10 WB result
// - fwd_rsrc_sel  out  2       rsrc operand source, same encoding
// - stall_cycles  out  SCNT_W  count of cycles with pc_hold=1, saturating
// BEHAVIOUR
// - Reset: all outputs 0; FSM = RUN; mc counter = 0.
//   - Applies from any state, including mid-MC_BUSY; the multi-cycle op is discarded, not retired.
// - Every func writes rdst. The register file does not bypass: a WB write is visible to ID the next cycle.
// - FSM RUN:
//   - If there is no stall, ID advances into EX at the clock edge: ex_* <= id_*; ex_valid <= id_valid.
//   - EX always advances into WB: wb_* <= ex_*.
//   - ID func 2'b11 advancing with MC_CYCLES>1: FSM -> MC_BUSY, cnt <= MC_CYCLES-1.
// - FSM MC_BUSY:
//   - ex_* hold their values; wb_valid <= 0.
//   - pc_hold = ifid_hold = 1 while cnt != 0; cnt decrements each cycle.
//   - When cnt reaches 0, the op leaves EX at the following edge (wb_valid <= 1). Same edge: FSM -> RUN, holds drop, ID advances.
//   - Net effect: pc_hold is high for exactly MC_CYCLES-1 cycles per func 2'b11.
// - Hazard stall in RUN (see CONFIGURATION):
//   - pc_hold = ifid_hold = 1.
//   - EX receives a bubble: ex_valid <= 0, ex_func/ex_rdst <= 0.
// - id_valid = 0: never stalls; a bubble advances into EX.
// - Forward selects are combinational from the ID and pipeline state.
//   - Each select is 00 when its operand matches no valid in-flight rdst.
//   - When both EX and WB match, EX (the newer) wins.
// - stall_cycles increments on every cycle with pc_hold=1. It holds at all-ones and does not wrap.
// CONFIGURATION
// - Macro HAZ_FWD_EN defined:
//   - RAW on a single-cycle producer raises no stall; fwd_*_sel selects 01 (EX) or 10 (WB).
//   - A consumer of a func 2'b11 result waits out MC_BUSY and then forwards from EX.
//     - Because MC_BUSY stalls ID for MC_CYCLES-1 cycles, the result reaches EX-forward range in time.
// - Macro HAZ_FWD_EN undefined:
//   - fwd_*_sel are tied to 00.
//   - Stall while id_valid and (id_rdst or id_rsrc) matches ex_rdst (ex_valid) or wb_rdst (wb_valid).
//   - A dependent instruction directly behind its producer stalls 2 cycles.
// TESTING
// - Dependent pair {00,r1,r2} then {01,r3,r1}, HAZ_FWD_EN on
//   -> no pc_hold; on the consumer's ID cycle fwd_rsrc_sel=01, fwd_rdst_sel=00.
// - Same pair, HAZ_FWD_EN off
//   -> pc_hold high 2 cycles; two bubbles (ex_valid=0); stall_cycles=2.
// - {11,r4,r5} with MC_CYCLES=4 followed by an independent op
//   -> mc_busy=1 for 3 cycles; pc_hold high 3 cycles; ex_* stable; wb_valid=1 with wb_rdst=4 exactly once.
// - MC op, then {00,r6,r4}, HAZ_FWD_EN on
//   -> consumer issues after MC_BUSY with fwd_rdst_sel=00, fwd_rsrc_sel=01.
// - reset asserted in the 2nd MC_BUSY cycle
//   -> next cycle all outputs 0, FSM=RUN, and r4 is never written (wb_valid stays 0).
// - id_valid=0 for 3 cycles after reset
//   -> ex_valid and wb_valid stay 0; pc_hold=0; stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: ID-side instruction inputs and pipeline control outputs.
// Master drives the IF/ID view; slave is the hazard controller.
interface pipe_hazard_if #(
  parameter int SCNT_W = 16
);
  logic              id_valid;
  logic [1:0]        id_func;
  logic [2:0]        id_rdst;
  logic [2:0]        id_rsrc;
  logic              pc_hold;
  logic              ifid_hold;
  logic              ex_valid;
  logic [1:0]        ex_func;
  logic [2:0]        ex_rdst;
  logic              wb_valid;
  logic [2:0]        wb_rdst;
  logic              mc_busy;
  logic [1:0]        fwd_rdst_sel;
  logic [1:0]        fwd_rsrc_sel;
  logic [SCNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_func, id_rdst, id_rsrc,
    input  pc_hold, ifid_hold,
    input  ex_valid, ex_func, ex_rdst,
    input  wb_valid, wb_rdst, mc_busy,
    input  fwd_rdst_sel, fwd_rsrc_sel,
    input  stall_cycles
  );

  modport slave (
    input  id_valid, id_func, id_rdst, id_rsrc,
    output pc_hold, ifid_hold,
    output ex_valid, ex_func, ex_rdst,
    output wb_valid, wb_rdst, mc_busy,
    output fwd_rdst_sel, fwd_rsrc_sel,
    output stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/bubble/forward sequencer for the 8-bit pipeline.
// Define HAZ_FWD_EN to forward instead of stalling on RAW hazards.
module pipe_hazard_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int SCNT_W    = 16
) (
  input logic        clk,
  input logic        reset,
  pipe_hazard_if.slave bus
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } state_t;

  localparam logic [3:0] MC_LOAD  = 4'(MC_CYCLES - 1);
  localparam logic       MC_MULTI = (MC_CYCLES > 1);

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;

  logic              ex_valid;
  logic [1:0]        ex_func;
  logic [2:0]        ex_rdst;
  logic              wb_valid;
  logic [2:0]        wb_rdst;
  logic [SCNT_W-1:0] scnt;

  logic              haz;
  logic              hold;
  logic              adv;
  logic              ex_hit_d;
  logic              ex_hit_s;
  logic              wb_hit_d;
  logic              wb_hit_s;
  logic [1:0]        fwd_d;
  logic [1:0]        fwd_s;

  assign ex_hit_d = ex_valid && (ex_rdst == bus.id_rdst);
  assign ex_hit_s = ex_valid && (ex_rdst == bus.id_rsrc);
  assign wb_hit_d = wb_valid && (wb_rdst == bus.id_rdst);
  assign wb_hit_s = wb_valid && (wb_rdst == bus.id_rsrc);

`ifdef HAZ_FWD_EN
  // RAW is resolved by bypass, so RUN never stalls
  assign haz = 1'b0;

  // operand source select; EX is newer than WB
  always_comb begin
    fwd_d = 2'b00;
    fwd_s = 2'b00;
    if (ex_hit_d) fwd_d = 2'b01;
    else if (wb_hit_d) fwd_d = 2'b10;
    if (ex_hit_s) fwd_s = 2'b01;
    else if (wb_hit_s) fwd_s = 2'b10;
  end
`else
  // without bypass, wait until producers have left WB
  assign haz = bus.id_valid &&
               (ex_hit_d || ex_hit_s ||
                wb_hit_d || wb_hit_s);
  assign fwd_d = 2'b00;
  assign fwd_s = 2'b00;
`endif

  // FSM state and multi-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state, hold and ID-advance decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      RUN: begin
        hold = haz;
        adv  = !haz;
        if (!haz && bus.id_valid &&
            bus.id_func == 2'b11 && MC_MULTI) begin
          state_n = MC_BUSY;
          cnt_n   = MC_LOAD;
        end
      end
      MC_BUSY: begin
        hold = (cnt != 4'd0);
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RUN;
      end
      default: begin
        state_n = RUN;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // EX and WB pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_func  <= 2'b00;
      ex_rdst  <= 3'd0;
      wb_valid <= 1'b0;
      wb_rdst  <= 3'd0;
    end else if (state == MC_BUSY) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      wb_rdst  <= ex_rdst;
      if (adv) begin
        ex_valid <= bus.id_valid;
        ex_func  <= bus.id_func;
        ex_rdst  <= bus.id_rdst;
      end else begin
        ex_valid <= 1'b0;
        ex_func  <= 2'b00;
        ex_rdst  <= 3'd0;
      end
    end
  end

  // saturating count of held cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt <= '0;
    end else if (hold && scnt != '1) begin
      scnt <= scnt + 1'b1;
    end
  end

  assign bus.pc_hold      = hold;
  assign bus.ifid_hold    = hold;
  assign bus.ex_valid     = ex_valid;
  assign bus.ex_func      = ex_func;
  assign bus.ex_rdst      = ex_rdst;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_rdst      = wb_rdst;
  assign bus.mc_busy      = (state == MC_BUSY);
  assign bus.fwd_rdst_sel = fwd_d;
  assign bus.fwd_rsrc_sel = fwd_s;
  assign bus.stall_cycles = scnt;

endmodule
